csa_mul_seq_ctrl: RTL and testbench

- Sequencer that computes a (4*DIGITS)x(4*DIGITS) unsigned product by time-multiplexing a single csa_mul_4b instance over all digit pairs.
- Accumulates the shifted partial products and returns the result over a valid/ready handshake.
- Sits between an operand producer and a result consumer wherever wide multiplies are needed without replicating the 4x4 array.

---
 rtl/csa_mul_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_csa_mul_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_mul_seq_ctrl.sv
// Sequential wide multiplier: one 4x4 carry-save array multiplier is reused over
// every digit pair, and the shifted partial products are accumulated into a 2W result.

module csa_mul_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] sum_s;
  logic [7:0] carry_s;
  logic [7:0] row_s;
  logic [7:0] maj_s;

  // Carry-save reduction of the four partial-product rows, then one carry-propagate add
  always_comb begin
    sum_s   = {4'b0000, a & {4{b[0]}}};
    carry_s = 8'h00;
    row_s   = 8'h00;
    maj_s   = 8'h00;
    for (int r = 1; r < 4; r++) begin
      row_s   = {4'b0000, a & {4{b[r]}}} << r;
      maj_s   = (sum_s & carry_s) | (sum_s & row_s) | (carry_s & row_s);
      sum_s   = sum_s ^ carry_s ^ row_s;
      carry_s = maj_s << 1;
    end
    p = sum_s + carry_s;
  end
endmodule

module csa_mul_seq_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_a,
  input  logic [4*DIGITS-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*DIGITS-1:0] out,
  output logic                busy
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    a_r, a_s, b_r, b_s;
  logic [IW-1:0]   i_r, i_s, j_r, j_s;
  logic [2*W-1:0]  acc_r, acc_s, out_r, out_s;
  logic [2*W-1:0]  pp_ext_s, sum_s;
  logic [3:0]      a_dig_s, b_dig_s;
  logic [7:0]      pp_s;
  logic [IW+2:0]   shift_s;

  assign a_dig_s = a_r[4*i_r +: 4];
  assign b_dig_s = b_r[4*j_r +: 4];

  csa_mul_4b u_mul (
    .a (a_dig_s),
    .b (b_dig_s),
    .p (pp_s)
  );

  // Align the current digit product to weight 16^(i+j) and add it to the running sum
  always_comb begin
    pp_ext_s      = {(2*W){1'b0}};
    pp_ext_s[7:0] = pp_s;
    shift_s       = {1'b0, i_r, 2'b00} + {1'b0, j_r, 2'b00};
    sum_s         = acc_r + (pp_ext_s << shift_s);
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    i_s     = i_r;
    j_s     = j_r;
    acc_s   = acc_r;
    out_s   = out_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s   = in_a;
          b_s   = in_b;
          acc_s = {(2*W){1'b0}};
          i_s   = {IW{1'b0}};
          j_s   = {IW{1'b0}};
          // A zero operand makes the product trivially zero, so skip the digit sweep
          if ((in_a == {W{1'b0}}) || (in_b == {W{1'b0}})) begin
            out_s   = {(2*W){1'b0}};
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s = sum_s;
        if (j_r == LAST) begin
          j_s = {IW{1'b0}};
          if (i_r == LAST) begin
            out_s   = sum_s;
            state_s = DONE;
          end else begin
            i_s = i_r + ONE;
          end
        end else begin
          j_s = j_r + ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      i_r     <= {IW{1'b0}};
      j_r     <= {IW{1'b0}};
      acc_r   <= {(2*W){1'b0}};
      out_r   <= {(2*W){1'b0}};
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      i_r     <= i_s;
      j_r     <= j_s;
      acc_r   <= acc_s;
      out_r   <= out_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out       = out_r;

endmodule

// File: tb/tb_csa_mul_seq_ctrl.sv
// Randomized self-checking bench for csa_mul_seq_ctrl with DIGITS=2; expected
// products and latencies come from plain integer arithmetic on the operands.

module tb_csa_mul_seq_ctrl;
  localparam int DIGITS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  csa_mul_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_wait in_ready=%b want 1", in_ready);
      bad++;
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
  endtask

  // edges counts the accepting edge as 1; ir_low counts samples with in_ready low
  task automatic wait_out(output int edges, output int ir_low);
    edges = 1; ir_low = 0;
    forever begin
      if (!in_ready) ir_low++;
      if (out_valid || edges >= 40) break;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0000) begin
      $display("FAIL reset got ir=%b ov=%b busy=%b out=%h want 1 0 0 0000", in_ready, out_valid, busy, out);
      bad++;
    end
  endtask

  task automatic test_ff();
    int e, irl;
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF);
    wait_out(e, irl);
    total++;
    if (out !== 16'hFE01 || out_valid !== 1'b1) begin
      $display("FAIL ff_result got ov=%b out=%h want 1 fe01", out_valid, out); bad++;
    end
    total++;
    if (e !== DIGITS*DIGITS+1) begin
      $display("FAIL ff_latency got %0d want %0d", e, DIGITS*DIGITS+1); bad++;
    end
    total++;
    if (irl !== 5) begin
      $display("FAIL ff_in_ready_low got %0d want 5", irl); bad++;
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL ff_one_cycle got ov=%b ir=%b want 0 1", out_valid, in_ready); bad++;
    end
  endtask

  task automatic test_5a3c();
    int e, irl;
    out_ready = 1'b1;
    accept(8'h5A, 8'h3C);
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_after_accept got %b want 1", busy); bad++;
    end
    wait_out(e, irl);
    total++;
    if (out !== 16'h1518 || busy !== 1'b1) begin
      $display("FAIL mul_5a3c got out=%h busy=%b want 1518 1", out, busy); bad++;
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL busy_after_handshake got %b want 0", busy); bad++;
    end
  endtask

  task automatic test_zero_skip();
    logic [7:0] za[2];
    logic [7:0] zb[2];
    za[0] = 8'h00; zb[0] = 8'hC3;
    za[1] = 8'h7E; zb[1] = 8'h00;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      accept(za[k], zb[k]);
      total++;
      if (out_valid !== 1'b1 || out !== 16'h0000 || busy !== 1'b1) begin
        $display("FAIL zero_skip_%0d got ov=%b out=%h busy=%b want 1 0000 1", k, out_valid, out, busy); bad++;
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL zero_skip_release_%0d got ov=%b ir=%b want 0 1", k, out_valid, in_ready); bad++;
      end
    end
  endtask

  task automatic test_backpressure();
    int e, irl;
    out_ready = 1'b0;
    accept(8'h12, 8'h34);
    wait_out(e, irl);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL backpressure_%0d got out=%h ov=%b ir=%b want 03a8 1 0", c, out, out_valid, in_ready); bad++;
      end
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    total++;
    if (out !== 16'h03A8 || out_valid !== 1'b1) begin
      $display("FAIL backpressure_hold got out=%h ov=%b want 03a8 1", out, out_valid); bad++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL backpressure_release got ov=%b ir=%b want 0 1", out_valid, in_ready); bad++;
    end
  endtask

  task automatic test_reset_mid();
    int e, irl;
    out_ready = 1'b1;
    accept(8'hAB, 8'hCD);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_mid got ov=%b out=%h ir=%b busy=%b want 0 0000 1 0", out_valid, out, in_ready, busy); bad++;
    end
    accept(8'h0F, 8'h11);
    wait_out(e, irl);
    total++;
    if (out !== 16'h00FF || out_valid !== 1'b1) begin
      $display("FAIL after_reset_mul got out=%h ov=%b want 00ff 1", out, out_valid); bad++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa[3];
    logic [7:0]  pb[3];
    logic [15:0] res[3];
    int          stamp[3];
    int          k, nres;
    pa[0] = 8'h03; pb[0] = 8'h05;
    pa[1] = 8'h10; pb[1] = 8'h10;
    pa[2] = 8'hFF; pb[2] = 8'h01;
    k = 0; nres = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (out_valid && nres < 3) begin
        res[nres] = out; stamp[nres] = c; nres++;
      end
      if (in_ready) begin
        if (k < 3) begin
          in_a = pa[k]; in_b = pb[k]; in_valid = 1'b1; k++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (nres == 3) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (nres !== 3) begin
      $display("FAIL b2b_count got %0d want 3", nres); bad++;
    end else begin
      for (int r = 0; r < 3; r++) begin
        total++;
        if (res[r] !== 16'(pa[r]) * 16'(pb[r])) begin
          $display("FAIL b2b_result_%0d got %h want %h", r, res[r], 16'(pa[r]) * 16'(pb[r])); bad++;
        end
      end
      for (int r = 1; r < 3; r++) begin
        total++;
        if (stamp[r] - stamp[r-1] !== DIGITS*DIGITS+2) begin
          $display("FAIL b2b_spacing_%0d got %0d want %0d", r, stamp[r] - stamp[r-1], DIGITS*DIGITS+2); bad++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [15:0] exp;
    int          exp_lat, e, irl, hold;
    for (int n = 0; n < 500; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h00;
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      exp     = 16'(a) * 16'(b);
      exp_lat = (a == 8'h00 || b == 8'h00) ? 1 : DIGITS*DIGITS+1;
      out_ready = 1'b0;
      accept(a, b);
      wait_out(e, irl);
      total++;
      if (out_valid !== 1'b1 || out !== exp) begin
        $display("FAIL rand_%0d %h*%h got ov=%b out=%h want 1 %h", n, a, b, out_valid, out, exp); bad++;
      end
      total++;
      if (e !== exp_lat) begin
        $display("FAIL rand_lat_%0d got %0d want %0d", n, e, exp_lat); bad++;
      end
      hold = 0;
      while (out_valid && hold < 20) begin
        out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
        hold++;
        if (out_valid) begin
          total++;
          if (out !== exp) begin
            $display("FAIL rand_hold_%0d got %h want %h", n, out, exp); bad++;
          end
        end
      end
      total++;
      if (out_valid !== 1'b0) begin
        $display("FAIL rand_release_%0d got ov=%b want 0", n, out_valid); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ff();
    test_5a3c();
    test_zero_skip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
